// File: rtl/tick_event_scheduler.sv
// Periodic per-channel event scheduler: each channel counts TICKs down from its
// period, and expiries are handed round-robin to one valid/ready consumer.
module tick_event_scheduler #(
  parameter int NCH      = 4,
  parameter int CH_W     = 2,
  parameter int PERIOD_W = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                TICK,
  input  logic                CFG_WE,
  input  logic [CH_W-1:0]     CFG_CH,
  input  logic                CFG_EN,
  input  logic [PERIOD_W-1:0] CFG_PERIOD,
  output logic                EVT_VALID,
  output logic [CH_W-1:0]     EVT_CH,
  input  logic                EVT_READY,
  output logic [NCH-1:0]      OVERRUN,
  input  logic                OVR_CLR
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t              r_state;
  logic                r_evtValid;
  logic [CH_W-1:0]     r_evtCh;
  logic [CH_W-1:0]     r_rrLast;
  logic [NCH-1:0]      r_en;
  logic [NCH-1:0]      r_pending;
  logic [NCH-1:0]      r_ovr;
  logic [PERIOD_W-1:0] r_period [NCH];
  logic [PERIOD_W-1:0] r_count  [NCH];

  logic                w_xfer;
  logic [NCH-1:0]      w_cfgHit;
  logic [NCH-1:0]      w_active;
  logic [NCH-1:0]      w_expire;
  logic [NCH-1:0]      w_clr;
  logic [NCH-1:0]      w_ovrSet;
  logic                w_grantFound;
  logic [CH_W-1:0]     w_grant;
  logic [CH_W-1:0]     w_idx;

  assign w_xfer    = r_evtValid && EVT_READY;
  assign EVT_VALID = r_evtValid;
  assign EVT_CH    = r_evtCh;
  assign OVERRUN   = r_ovr;

  // A config write owns its channel for the cycle, so a coincident tick is dropped.
  always_comb begin
    w_cfgHit = '0;
    w_active = '0;
    w_expire = '0;
    w_clr    = '0;
    w_ovrSet = '0;
    for (int i = 0; i < NCH; i++) begin
      w_cfgHit[i] = CFG_WE && (CFG_CH == CH_W'(i));
      w_active[i] = !w_cfgHit[i] && TICK && r_en[i] && (r_period[i] != '0);
      w_expire[i] = w_active[i] && (r_count[i] == PERIOD_W'(1));
      w_clr[i]    = w_xfer && (r_evtCh == CH_W'(i));
      w_ovrSet[i] = w_expire[i] && r_pending[i] && !w_clr[i];
    end
  end

  always_comb begin
    w_grantFound = 1'b0;
    w_grant      = '0;
    w_idx        = '0;
    for (int k = NCH; k >= 1; k--) begin
      w_idx = r_rrLast + CH_W'(k);
      if (r_pending[w_idx]) begin
        w_grantFound = 1'b1;
        w_grant      = w_idx;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_en      <= '0;
      r_pending <= '0;
      r_ovr     <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_period[i] <= '0;
        r_count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_cfgHit[i]) begin
          r_en[i]      <= CFG_EN;
          r_period[i]  <= CFG_PERIOD;
          r_count[i]   <= CFG_PERIOD;
          r_pending[i] <= 1'b0;
        end else if (w_expire[i]) begin
          r_count[i]   <= r_period[i];
          r_pending[i] <= 1'b1;
        end else begin
          if (w_active[i]) begin
            r_count[i] <= r_count[i] - PERIOD_W'(1);
          end
          if (w_clr[i]) begin
            r_pending[i] <= 1'b0;
          end
        end
      end
      r_ovr <= (OVR_CLR ? '0 : r_ovr) | w_ovrSet;
    end
  end

  // Grant decisions use the pending bits as they stood before this edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_evtValid <= 1'b0;
      r_evtCh    <= '0;
      r_rrLast   <= CH_W'(NCH - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grantFound) begin
            r_evtValid <= 1'b1;
            r_evtCh    <= w_grant;
            r_rrLast   <= w_grant;
            r_state    <= OFFER;
          end
        end
        OFFER: begin
          if (EVT_READY) begin
            r_evtValid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_evtValid <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule
